// File: rtl/uart_hex_packet_tx_if.sv
// Word-source and byte-sink signals of the hex packet serialiser.
// The handler/UART side uses master; the serialiser uses slave.
interface uart_hex_packet_tx_if #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned COUNT_WIDTH = 16
);
   logic                   send_en;
   logic [DATA_WIDTH-1:0]  status;
   logic [DATA_WIDTH-1:0]  address;
   logic [COUNT_WIDTH-1:0] data_count;
   logic [DATA_WIDTH-1:0]  data;
   logic                   data_req;
   logic                   data_ack;
   logic                   uart_ready;
   logic                   uart_byte_en;
   logic [7:0]             uart_byte;
   logic                   handler_ready;
   logic                   busy;
   logic                   finished;

   modport master (
      output send_en, status, address, data_count, data, data_ack, uart_ready,
      input  data_req, uart_byte_en, uart_byte, handler_ready, busy, finished
   );

   modport slave (
      input  send_en, status, address, data_count, data, data_ack, uart_ready,
      output data_req, uart_byte_en, uart_byte, handler_ready, busy, finished
   );
endinterface

// File: rtl/uart_hex_packet_tx.sv
// Serialises status, address and a burst of data words as an uppercase ASCII-hex
// UART packet: START_CHAR, hex fields MSB-nibble first, optional EOL_CHAR.
module uart_hex_packet_tx #(
   parameter int unsigned DATA_WIDTH  = 32,
   parameter int unsigned COUNT_WIDTH = 16,
   parameter logic [7:0]  START_CHAR  = 8'h53,
   parameter bit          EOL_EN      = 1'b1,
   parameter logic [7:0]  EOL_CHAR    = 8'h0A
) (
   input logic clk,
   input logic rst,
   uart_hex_packet_tx_if.slave bus
);
   localparam int unsigned NIB = DATA_WIDTH / 4;
   localparam int unsigned NCW = $clog2(NIB) + 1;
   localparam logic [NCW-1:0] LAST_NIB = NCW'(NIB - 1);

   typedef enum logic [2:0] {IDLE, START, STATUS, ADDR, DREQ, DATA, EOL, DONE} state_t;

   state_t                 state, state_n;
   logic [NCW-1:0]         nib_q, nib_n;
   logic [COUNT_WIDTH-1:0] wcount_q, wcount_n;
   logic [DATA_WIDTH-1:0]  shift_q, shift_n;
   logic [DATA_WIDTH-1:0]  addr_q, addr_n;
   logic [7:0]             byte_q, byte_n;
   logic                   en_q, en_n;
   logic                   req_q, req_n;
   logic                   fin_q, fin_n;
   logic                   issue;

   function automatic logic [7:0] hex_char(input logic [3:0] n);
      return (n < 4'd10) ? 8'h30 + 8'(n) : 8'h37 + 8'(n);
   endfunction

   // At most every other cycle, so a one-cycle lag in uart_ready is tolerated
   assign issue = bus.uart_ready & ~en_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         nib_q    <= '0;
         wcount_q <= '0;
         shift_q  <= '0;
         addr_q   <= '0;
         byte_q   <= '0;
         en_q     <= 1'b0;
         req_q    <= 1'b0;
         fin_q    <= 1'b0;
      end else begin
         state    <= state_n;
         nib_q    <= nib_n;
         wcount_q <= wcount_n;
         shift_q  <= shift_n;
         addr_q   <= addr_n;
         byte_q   <= byte_n;
         en_q     <= en_n;
         req_q    <= req_n;
         fin_q    <= fin_n;
      end
   end

   always_comb begin
      state_n  = state;
      nib_n    = nib_q;
      wcount_n = wcount_q;
      shift_n  = shift_q;
      addr_n   = addr_q;
      byte_n   = byte_q;
      en_n     = 1'b0;
      req_n    = 1'b0;
      fin_n    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.send_en && bus.uart_ready) begin
               shift_n  = bus.status;
               addr_n   = bus.address;
               wcount_n = bus.data_count;
               nib_n    = '0;
               state_n  = START;
            end
         end
         START: begin
            if (issue) begin
               en_n    = 1'b1;
               byte_n  = START_CHAR;
               state_n = STATUS;
            end
         end
         STATUS, ADDR, DATA: begin
            if (issue) begin
               en_n    = 1'b1;
               byte_n  = hex_char(shift_q[DATA_WIDTH-1 -: 4]);
               shift_n = shift_q << 4;
               nib_n   = nib_q + NCW'(1);
               if (nib_q == LAST_NIB) begin
                  nib_n = '0;
                  case (state)
                     STATUS: begin
                        shift_n = addr_q;
                        state_n = ADDR;
                     end
                     ADDR: state_n = DREQ;
                     default: begin
                        if (wcount_q != '0) begin
                           wcount_n = wcount_q - COUNT_WIDTH'(1);
                           state_n  = DREQ;
                        end else begin
                           state_n = EOL_EN ? EOL : DONE;
                        end
                     end
                  endcase
               end
            end
         end
         DREQ: begin
            if (req_q && bus.data_ack) begin
               shift_n = bus.data;
               nib_n   = '0;
               state_n = DATA;
            end
         end
         EOL: begin
            if (issue) begin
               en_n    = 1'b1;
               byte_n  = EOL_CHAR;
               state_n = DONE;
            end
         end
         DONE: state_n = IDLE;
         default: state_n = IDLE;
      endcase
      req_n = (state_n == DREQ);
      fin_n = (state_n == DONE);
   end

   assign bus.uart_byte_en  = en_q;
   assign bus.uart_byte     = byte_q;
   assign bus.data_req      = req_q;
   assign bus.finished      = fin_q;
   assign bus.busy          = (state != IDLE);
   assign bus.handler_ready = (state == IDLE) & bus.uart_ready;
endmodule

// File: tb/tb_uart_hex_packet_tx.sv
// Randomised self-checking bench for uart_hex_packet_tx (32-bit with EOL, 16-bit without).
module tb_uart_hex_packet_tx;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_hex_packet_tx_if #(.DATA_WIDTH(32), .COUNT_WIDTH(16)) bus ();
   uart_hex_packet_tx_if #(.DATA_WIDTH(16), .COUNT_WIDTH(16)) bus16 ();

   uart_hex_packet_tx #(.DATA_WIDTH(32), .COUNT_WIDTH(16), .START_CHAR(8'h53),
                        .EOL_EN(1'b1), .EOL_CHAR(8'h0A))
      dut (.clk(clk), .rst(rst), .bus(bus.slave));

   uart_hex_packet_tx #(.DATA_WIDTH(16), .COUNT_WIDTH(16), .START_CHAR(8'h53),
                        .EOL_EN(1'b0), .EOL_CHAR(8'h0A))
      dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

   int n_checks = 0;
   int n_pass   = 0;
   string hexs  = "0123456789ABCDEF";
   logic [7:0] exp_q[$];

   // Reference: each word becomes nib uppercase hex characters, most significant first
   function automatic void add_word(input logic [31:0] w, input int nib);
      for (int i = nib - 1; i >= 0; i--)
         exp_q.push_back(8'(hexs[int'((w >> (4 * i)) & 32'hF)]));
   endfunction

   // Byte/handshake monitors, sampled on the falling edge
   logic [7:0] got_q[$];
   logic [7:0] got16_q[$];
   int hs_cnt = 0, fin_cnt = 0, fin_at = 0, b2b_err = 0, rdy_err = 0;
   int fin16_cnt = 0;
   logic en_prev = 1'b0, rdy_prev = 1'b0;

   always @(negedge clk) begin
      if (bus.uart_byte_en === 1'b1) begin
         got_q.push_back(bus.uart_byte);
         if (en_prev) b2b_err++;
         if (!rdy_prev) rdy_err++;
      end
      if (bus.data_req === 1'b1 && bus.data_ack === 1'b1) hs_cnt++;
      if (bus.finished === 1'b1) begin
         fin_cnt++;
         fin_at = got_q.size();
      end
      en_prev  = (bus.uart_byte_en === 1'b1);
      rdy_prev = (bus.uart_ready === 1'b1);
   end

   always @(negedge clk) begin
      if (bus16.uart_byte_en === 1'b1) got16_q.push_back(bus16.uart_byte);
      if (bus16.finished === 1'b1) fin16_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic run_packet(input string name, input logic [31:0] st, input logic [31:0] ad,
                             input logic [31:0] words[$], input int min_dly, input int max_dly,
                             input bit bp, input bit poke, output logic [7:0] got[$]);
      int base, hs0, fin0, b2b0, rdy0, idx, dly, cyc, first_bad;
      bit will_acc, done, acking, poked;
      logic [7:0] gb;
      exp_q.delete();
      exp_q.push_back(8'h53);
      add_word(st, 8);
      add_word(ad, 8);
      foreach (words[i]) add_word(words[i], 8);
      exp_q.push_back(8'h0A);
      base = got_q.size(); hs0 = hs_cnt; fin0 = fin_cnt; b2b0 = b2b_err; rdy0 = rdy_err;
      idx = 0; dly = int'($urandom_range(min_dly, max_dly));
      done = 0; acking = 0; poked = 0;
      @(posedge clk); #1;
      bus.uart_ready = 1'b1; bus.status = st; bus.address = ad;
      bus.data_count = 16'(words.size() - 1); bus.send_en = 1'b1;
      @(posedge clk); #1;
      bus.send_en = 1'b0; bus.status = ~st; bus.address = ~ad; bus.data_count = 16'($urandom);
      for (cyc = 0; cyc < 4000 && !done; cyc++) begin
         if (bp) bus.uart_ready = ($urandom_range(0, 2) != 0);
         if (bus.data_req) begin
            if (!acking) begin
               if (dly == 0 && idx < words.size()) begin
                  bus.data_ack = 1'b1; bus.data = words[idx]; acking = 1;
               end else begin
                  bus.data_ack = 1'b0;
                  if (dly > 0) dly--;
               end
            end
         end else begin
            bus.data_ack = 1'($urandom_range(0, 1));
            bus.data = $urandom;
         end
         bus.send_en = 1'b0;
         if (poke && !poked && got_q.size() - base == 20) begin
            bus.send_en = 1'b1; bus.status = 32'hFFFF_FFFF; bus.address = 32'h0;
            bus.data_count = 16'hFFFF; poked = 1;
            n_checks++;
            if (bus.busy !== 1'b1 || bus.handler_ready !== 1'b0)
               $display("FAIL %s busy_flags: busy=%b handler_ready=%b want 1/0",
                        name, bus.busy, bus.handler_ready);
            else n_pass++;
         end
         @(negedge clk);
         will_acc = (bus.data_req === 1'b1) && (bus.data_ack === 1'b1);
         if (bus.finished === 1'b1) done = 1;
         @(posedge clk); #1;
         if (will_acc) begin
            bus.data_ack = 1'b0; acking = 0; idx++;
            dly = int'($urandom_range(min_dly, max_dly));
         end
      end
      bus.send_en = 1'b0; bus.uart_ready = 1'b1; bus.data_ack = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      n_checks++;
      if (!done) $display("FAIL %s timeout: finished seen=%0d want 1", name, done);
      else n_pass++;
      if (poke) begin
         n_checks++;
         if (!poked) $display("FAIL %s poke_reached: got %0d want 1", name, poked);
         else n_pass++;
      end
      n_checks++;
      if (got_q.size() - base != exp_q.size())
         $display("FAIL %s length: got %0d want %0d", name, got_q.size() - base, exp_q.size());
      else n_pass++;
      first_bad = -1; gb = 8'h00;
      for (int i = 0; i < exp_q.size(); i++) begin
         gb = (base + i < got_q.size()) ? got_q[base + i] : 8'hxx;
         if (gb !== exp_q[i]) begin first_bad = i; break; end
      end
      n_checks++;
      if (first_bad != -1)
         $display("FAIL %s bytes: index %0d got %02h want %02h", name, first_bad, gb, exp_q[first_bad]);
      else n_pass++;
      n_checks++;
      if (hs_cnt - hs0 != words.size())
         $display("FAIL %s handshakes: got %0d want %0d", name, hs_cnt - hs0, words.size());
      else n_pass++;
      n_checks++;
      if (fin_cnt - fin0 != 1) $display("FAIL %s finished_pulses: got %0d want 1", name, fin_cnt - fin0);
      else n_pass++;
      n_checks++;
      if (fin_at - base != exp_q.size())
         $display("FAIL %s finish_position: got %0d want %0d", name, fin_at - base, exp_q.size());
      else n_pass++;
      n_checks++;
      if (b2b_err != b2b0) $display("FAIL %s back_to_back: got %0d want 0", name, b2b_err - b2b0);
      else n_pass++;
      n_checks++;
      if (rdy_err != rdy0) $display("FAIL %s strobe_not_ready: got %0d want 0", name, rdy_err - rdy0);
      else n_pass++;
      got.delete();
      for (int i = base; i < got_q.size(); i++) got.push_back(got_q[i]);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.uart_ready = 1'b0; bus16.uart_ready = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({bus.uart_byte_en, bus.finished, bus.data_req, bus.busy, bus.uart_byte} !== 12'h000)
         $display("FAIL reset_outputs: en/fin/req/busy/byte=%b%b%b%b/%02h want 0",
                  bus.uart_byte_en, bus.finished, bus.data_req, bus.busy, bus.uart_byte);
      else n_pass++;
      n_checks++;
      if ({bus16.uart_byte_en, bus16.finished, bus16.data_req, bus16.busy, bus16.uart_byte} !== 12'h000)
         $display("FAIL reset_outputs16: en/fin/req/busy/byte=%b%b%b%b/%02h want 0",
                  bus16.uart_byte_en, bus16.finished, bus16.data_req, bus16.busy, bus16.uart_byte);
      else n_pass++;
      n_checks++;
      if (bus.handler_ready !== 1'b0) $display("FAIL ready_low: got %b want 0", bus.handler_ready);
      else n_pass++;
      bus.uart_ready = 1'b1; bus16.uart_ready = 1'b1;
      #1;
      n_checks++;
      if (bus.handler_ready !== 1'b1) $display("FAIL ready_high: got %b want 1", bus.handler_ready);
      else n_pass++;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_defaults();
      logic [31:0] w[$];
      logic [7:0] g[$];
      w.push_back(32'hDEAD_BEEF);
      run_packet("defaults", 32'h0000_0001, 32'h0100_0000, w, 1, 1, 1'b0, 1'b0, g);
   endtask

   task automatic test_burst();
      logic [31:0] w[$];
      logic [7:0] g[$];
      w.push_back(32'h0); w.push_back(32'hFFFF_FFFF); w.push_back(32'h1234_ABCD);
      run_packet("burst", $urandom, $urandom, w, 0, 5, 1'b0, 1'b0, g);
   endtask

   task automatic test_backpressure();
      logic [31:0] w[$];
      logic [7:0] g0[$], g1[$];
      logic [31:0] st, ad;
      int n;
      st = $urandom; ad = $urandom; n = int'($urandom_range(1, 4));
      for (int i = 0; i < n; i++) w.push_back($urandom);
      run_packet("smooth", st, ad, w, 0, 3, 1'b0, 1'b0, g0);
      run_packet("backpressure", st, ad, w, 0, 3, 1'b1, 1'b0, g1);
      n_checks++;
      if (g0 != g1) $display("FAIL bp_identical: got %0d bytes vs %0d bytes differing", g1.size(), g0.size());
      else n_pass++;
   endtask

   task automatic test_busy_gating();
      logic [31:0] w[$];
      logic [7:0] g[$];
      w.push_back($urandom); w.push_back($urandom);
      run_packet("busy_gating", $urandom, $urandom, w, 0, 2, 1'b0, 1'b1, g);
   endtask

   task automatic test_reset_mid();
      logic [31:0] w[$];
      logic [7:0] g[$];
      int base, fin0, n, cyc;
      base = got_q.size(); fin0 = fin_cnt;
      @(posedge clk); #1;
      bus.uart_ready = 1'b1; bus.status = 32'h1111_2222; bus.address = 32'h3333_4444;
      bus.data_count = 16'h0; bus.data_ack = 1'b0; bus.send_en = 1'b1;
      @(posedge clk); #1;
      bus.send_en = 1'b0;
      for (cyc = 0; cyc < 500 && got_q.size() - base < 12; cyc++) begin
         @(posedge clk); #1;
      end
      n_checks++;
      if (got_q.size() - base < 12) $display("FAIL rst_mid_reach_addr: got %0d bytes want 12", got_q.size() - base);
      else n_pass++;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if ({bus.uart_byte_en, bus.finished, bus.data_req, bus.busy, bus.uart_byte} !== 12'h000)
         $display("FAIL rst_mid_outputs: en/fin/req/busy/byte=%b%b%b%b/%02h want 0",
                  bus.uart_byte_en, bus.finished, bus.data_req, bus.busy, bus.uart_byte);
      else n_pass++;
      n_checks++;
      if (bus.handler_ready !== 1'b1) $display("FAIL rst_mid_ready: got %b want 1", bus.handler_ready);
      else n_pass++;
      n = got_q.size();
      repeat (20) @(negedge clk);
      n_checks++;
      if (got_q.size() != n || fin_cnt != fin0)
         $display("FAIL rst_mid_quiet: extra bytes %0d finished %0d want 0/0", got_q.size() - n, fin_cnt - fin0);
      else n_pass++;
      w.push_back($urandom);
      run_packet("after_reset", $urandom, $urandom, w, 0, 2, 1'b0, 1'b0, g);
   endtask

   task automatic test_width16();
      logic [15:0] w[2];
      logic [15:0] ad;
      int base, fin0, idx, cyc, first_bad;
      bit done, will_acc;
      logic [7:0] gb;
      logic [31:0] field;
      w[0] = 16'($urandom); w[1] = 16'($urandom); ad = 16'($urandom);
      exp_q.delete();
      exp_q.push_back(8'h53);
      add_word(32'h0000_A5F0, 4);
      add_word(32'(ad), 4);
      add_word(32'(w[0]), 4);
      add_word(32'(w[1]), 4);
      base = got16_q.size(); fin0 = fin16_cnt; idx = 0; done = 0;
      @(posedge clk); #1;
      bus16.uart_ready = 1'b1; bus16.status = 16'hA5F0; bus16.address = ad;
      bus16.data_count = 16'd1; bus16.data_ack = 1'b0; bus16.send_en = 1'b1;
      @(posedge clk); #1;
      bus16.send_en = 1'b0; bus16.status = 16'h0; bus16.address = 16'h0;
      for (cyc = 0; cyc < 2000 && !done; cyc++) begin
         if (bus16.data_req && !bus16.data_ack && idx < 2) begin
            bus16.data_ack = 1'b1; bus16.data = w[idx];
         end
         @(negedge clk);
         will_acc = (bus16.data_req === 1'b1) && (bus16.data_ack === 1'b1);
         if (bus16.finished === 1'b1) done = 1;
         @(posedge clk); #1;
         if (will_acc) begin bus16.data_ack = 1'b0; idx++; end
      end
      repeat (6) @(posedge clk);
      #1;
      n_checks++;
      if (!done) $display("FAIL w16 timeout: finished seen=%0d want 1", done);
      else n_pass++;
      n_checks++;
      if (got16_q.size() - base != 17) $display("FAIL w16 length: got %0d want 17", got16_q.size() - base);
      else n_pass++;
      field = 32'h0;
      if (got16_q.size() - base >= 5)
         field = {got16_q[base + 1], got16_q[base + 2], got16_q[base + 3], got16_q[base + 4]};
      n_checks++;
      if (field !== 32'h4135_4630) $display("FAIL w16 status_field: got %08h want 41354630", field);
      else n_pass++;
      first_bad = -1; gb = 8'h00;
      for (int i = 0; i < exp_q.size(); i++) begin
         gb = (base + i < got16_q.size()) ? got16_q[base + i] : 8'hxx;
         if (gb !== exp_q[i]) begin first_bad = i; break; end
      end
      n_checks++;
      if (first_bad != -1)
         $display("FAIL w16 bytes: index %0d got %02h want %02h", first_bad, gb, exp_q[first_bad]);
      else n_pass++;
      n_checks++;
      if (fin16_cnt - fin0 != 1) $display("FAIL w16 finished_pulses: got %0d want 1", fin16_cnt - fin0);
      else n_pass++;
   endtask

   initial begin
      bus.send_en = 1'b0; bus.status = '0; bus.address = '0; bus.data_count = '0;
      bus.data = '0; bus.data_ack = 1'b0; bus.uart_ready = 1'b0;
      bus16.send_en = 1'b0; bus16.status = '0; bus16.address = '0; bus16.data_count = '0;
      bus16.data = '0; bus16.data_ack = 1'b0; bus16.uart_ready = 1'b0;
      test_reset();
      test_defaults();
      test_burst();
      test_backpressure();
      test_busy_gating();
      test_reset_mid();
      test_width16();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule

// File: doc/uart_hex_packet_tx.md
Name: uart_hex_packet_tx

Overview:
Parametrised UART response serialiser for the wishbone master handler. It converts a status word, an address word and a run of data words into an uppercase ASCII-hex byte stream, framed by a start character and an optional end-of-line character. It sits between the master handler (word source) and the UART transmitter (byte sink). Word width is generalised, and multi-word bursts are fetched through an explicit data request/acknowledge handshake.

Parameters:
DATA_WIDTH, 32, width of the status/address/data words; must be a multiple of 4. NIB = DATA_WIDTH/4.
COUNT_WIDTH, 16, width of data_count.
START_CHAR, 8'h53, first byte of every packet ('S').
EOL_EN, 1, 1 = append EOL_CHAR after the last data word.
EOL_CHAR, 8'h0A, terminator byte.

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-high reset
send_en  input  1  start request; sampled only while handler_ready=1
status  input  DATA_WIDTH  status word, latched on accepted send_en
address  input  DATA_WIDTH  address word, latched on accepted send_en
data_count  input  COUNT_WIDTH  number of data words minus one, latched on accepted send_en
data  input  DATA_WIDTH  current data word, latched when data_req & data_ack
data_req  output  1  high while waiting for the next data word
data_ack  input  1  data valid; qualifies data while data_req=1
uart_ready  input  1  UART transmitter can accept a byte
uart_byte_en  output  1  one-cycle strobe; byte is valid in the same cycle
byte  output  8  byte to transmit
handler_ready  output  1  equals (state==IDLE) & uart_ready; combinational
busy  output  1  equals state!=IDLE
finished  output  1  one-cycle pulse when the packet is complete

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE; byte=0; uart_byte_en=0; finished=0; data_req=0; nibble and word counters=0. Reset mid-packet aborts with no further output, and no finished pulse is generated.
- Byte issue rule: a byte is emitted in a cycle where uart_ready=1 and uart_byte_en was 0 in the previous cycle. The block therefore never issues back-to-back strobes, which tolerates a one-cycle lag in uart_ready. uart_byte_en defaults to 0 every cycle.
- Hex encoding: nibble n<10 gives n+8'h30; otherwise n+8'h37 ('A'–'F'). Nibbles are sent MSB first; the shift register shifts left by 4 per byte.
- States:
  - IDLE: waits for send_en & uart_ready. On acceptance it latches status, address and data_count into wcount, and goes to START. send_en is ignored in all other states.
  - START: emits START_CHAR, then goes to STATUS.
  - STATUS: emits NIB bytes, then goes to ADDR.
  - ADDR: emits NIB bytes, then goes to DREQ.
  - DREQ: data_req=1, and no bytes are emitted. On data_ack=1 it latches data, drops data_req in the next cycle, and goes to DATA. data_ack while data_req=0 is ignored. Waiting has no timeout.
  - DATA: emits NIB bytes. After the last nibble: if wcount>0, it decrements wcount and goes to DREQ; otherwise it goes to EOL when EOL_EN=1, else to DONE.
  - EOL: emits EOL_CHAR, then goes to DONE.
  - DONE: finished=1 for one cycle, then goes to IDLE. handler_ready can rise in the following cycle.
  - Illegal state encodings go to IDLE.
- Packet length in bytes = 1 + 2·NIB + (data_count+1)·NIB + EOL_EN.
- Each data word must be acknowledged exactly once. Total data_ack acceptances = data_count+1.
- Nibble counter width is clog2(NIB)+1. It resets to 0 on every state change.
- If uart_ready drops mid-word, the block stalls holding all state. Byte order and content are unaffected.

Test Plan:
- Defaults. Inputs status=32'h0000_0001, address=32'h0100_0000, data=32'hDEAD_BEEF, count=0; data_ack is driven one cycle after data_req; uart_ready=1. Required stream: "S0000000101000000DEADBEEF\n" (26 bytes), exactly one data_req/ack handshake, one finished pulse, and no two consecutive uart_byte_en cycles.
- Burst. count=2, with data words 32'h0, 32'hFFFF_FFFF and 32'h1234_ABCD acknowledged with random 0–5 cycle delays. Required: 3 handshakes; data bytes "00000000FFFFFFFF1234ABCD"; 42 bytes total; finished only after the final EOL.
- Width/EOL variant. DATA_WIDTH=16, EOL_EN=0, status=16'hA5F0. Required: the status field is "A5F0", and the packet has no terminator byte.
- Back-pressure. uart_ready is toggled pseudo-randomly through a packet. Required: the byte sequence is identical to the uninterrupted run, and strobes occur only while uart_ready=1.
- Reset mid-packet. rst is asserted during ADDR. Required: in the next cycle the block is in IDLE with all outputs 0 and no finished pulse. A subsequent send_en produces a complete, correct packet.
- Busy gating. send_en is pulsed during DATA with different inputs. Required: it is ignored, and the current packet content is unchanged.
